// File: rtl/exclusive_max_n.sv
// exclusive_max_n
//   N-input clocked exclusive-max temporal primitive. Within a gamma cycle
//   (opened by gamma_rst) each enabled spike input is recorded once. When
//   every enabled input has arrived, a PULSE_WIDTH-cycle pulse is emitted on
//   q. In exclusive mode the pulse is suppressed if the final arrival cycle
//   holds more than one input. The arrival time and index of the latest
//   input are reported.
//
// Ports
//   aclk       clock
//   grst_n     async active-low reset
//   gamma_rst  sync start of gamma cycle; captures mode/in_en, clears state
//   mode       0 = plain max, 1 = exclusive max
//   in_en      channel enable mask
//   spike      spike inputs (level; only the first rise per cycle counts)
//   q          output pulse
//   winner     lowest index among the inputs of the final arrival cycle
//   max_time   in-gamma time at the final arrival
//   tie        final arrival cycle had more than one input
//   timeout    time counter saturated before completion
//   done       one-cycle strobe when the result resolves

// Per-channel arrival tracker: one instance per spike input.
module exclusive_max_n_lane (
  input  logic aclk,
  input  logic grst_n,
  input  logic clr,
  input  logic armed,
  input  logic spike,
  input  logic en,
  output logic arr,
  output logic seen
);
  // First sighting of this channel in the current gamma cycle.
  assign arr = armed & spike & en & ~seen;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n)    seen <= 1'b0;
    else if (clr)   seen <= 1'b0;
    else if (arr)   seen <= 1'b1;
  end
endmodule

module exclusive_max_n #(
  parameter  int NUM_INPUTS        = 4,
  parameter  int PULSE_WIDTH       = 8,
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int IDX_W             = $clog2(NUM_INPUTS)
) (
  input  logic                         aclk,
  input  logic                         grst_n,
  input  logic                         gamma_rst,
  input  logic                         mode,
  input  logic [NUM_INPUTS-1:0]        in_en,
  input  logic [NUM_INPUTS-1:0]        spike,
  output logic                         q,
  output logic [IDX_W-1:0]             winner,
  output logic [GAMMA_CYCLE_WIDTH-1:0] max_time,
  output logic                         tie,
  output logic                         timeout,
  output logic                         done
);
  localparam int PW_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [PW_W-1:0]              PW_ONE = PW_W'(1);
  localparam logic [PW_W-1:0]              PW_MAX = PW_W'(PULSE_WIDTH);
  localparam logic [GAMMA_CYCLE_WIDTH-1:0] T_ONE  = GAMMA_CYCLE_WIDTH'(1);
  localparam logic [NUM_INPUTS-1:0]        V_ONE  = NUM_INPUTS'(1);

  typedef enum logic [1:0] {ARMED, FIRE, HOLD} state_t;

  state_t state, state_nx;

  logic                         mode_q;
  logic [NUM_INPUTS-1:0]        en_q;
  logic [NUM_INPUTS-1:0]        arr, seen;
  logic [GAMMA_CYCLE_WIDTH-1:0] t_cnt;
  logic [PW_W-1:0]              pw_cnt;

  logic             armed, complete, tie_c, t_sat, pw_done, suppress;
  logic [IDX_W-1:0] win_c;

  assign armed = (state == ARMED);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    exclusive_max_n_lane u_lane (
      .aclk   (aclk),
      .grst_n (grst_n),
      .clr    (gamma_rst),
      .armed  (armed),
      .spike  (spike[i]),
      .en     (en_q[i]),
      .arr    (arr[i]),
      .seen   (seen[i])
    );
  end

  // arr is already gated by armed, so arr != 0 implies ARMED.
  assign complete = (en_q != '0) && ((seen | arr) == en_q) && (arr != '0);
  // More than one bit set: clearing the lowest set bit leaves something.
  assign tie_c    = (arr & (arr - V_ONE)) != '0;
  assign t_sat    = (t_cnt == '1);
  assign pw_done  = (pw_cnt == PW_MAX);
  assign suppress = mode_q & tie_c;

  // Lowest set index in arr: scan high to low so the last hit wins.
  always_comb begin
    win_c = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--)
      if (arr[i]) win_c = IDX_W'(i);
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) state <= ARMED;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARMED: begin
        if (complete)   state_nx = suppress ? HOLD : FIRE;
        else if (t_sat) state_nx = HOLD;
      end
      FIRE:    if (pw_done) state_nx = HOLD;
      HOLD:    state_nx = HOLD;
      default: state_nx = ARMED;
    endcase
    if (gamma_rst) state_nx = ARMED;
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      mode_q   <= 1'b0;
      en_q     <= '1;
      t_cnt    <= '0;
      pw_cnt   <= '0;
      q        <= 1'b0;
      winner   <= '0;
      max_time <= '0;
      tie      <= 1'b0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else if (gamma_rst) begin
      mode_q   <= mode;
      en_q     <= in_en;
      t_cnt    <= '0;
      pw_cnt   <= '0;
      q        <= 1'b0;
      winner   <= '0;
      max_time <= '0;
      tie      <= 1'b0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!t_sat) t_cnt <= t_cnt + T_ONE;
      unique case (state)
        ARMED: begin
          if (complete) begin
            max_time <= t_cnt;
            winner   <= win_c;
            tie      <= tie_c;
            done     <= 1'b1;
            if (!suppress) begin
              q      <= 1'b1;
              pw_cnt <= PW_ONE;
            end
          end else if (t_sat) begin
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        FIRE: begin
          if (pw_done) q      <= 1'b0;
          else         pw_cnt <= pw_cnt + PW_ONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exclusive_max_n.sv
module tb_exclusive_max_n;
  logic        aclk = 1'b0;
  logic        grst_n, gamma_rst, mode;
  logic [3:0]  in_en, spike;
  logic        q, tie, timeout, done;
  logic [1:0]  winner;
  logic [15:0] max_time;
  logic        q4, tie4, timeout4, done4;
  logic [1:0]  winner4;
  logic [3:0]  max_time4;

  always #5 aclk = ~aclk;

  exclusive_max_n #(.NUM_INPUTS(4), .PULSE_WIDTH(8), .GAMMA_CYCLE_WIDTH(16)) u_dut (
    .aclk(aclk), .grst_n(grst_n), .gamma_rst(gamma_rst), .mode(mode), .in_en(in_en),
    .spike(spike), .q(q), .winner(winner), .max_time(max_time), .tie(tie),
    .timeout(timeout), .done(done));

  // Narrow time counter so saturation is reachable in a few cycles.
  exclusive_max_n #(.NUM_INPUTS(4), .PULSE_WIDTH(8), .GAMMA_CYCLE_WIDTH(4)) u_dut4 (
    .aclk(aclk), .grst_n(grst_n), .gamma_rst(gamma_rst), .mode(mode), .in_en(in_en),
    .spike(spike), .q(q4), .winner(winner4), .max_time(max_time4), .tie(tie4),
    .timeout(timeout4), .done(done4));

  typedef logic [3:0] sched_t [0:23];
  typedef struct {
    int          done_edge;
    int          q_first;
    int          q_cnt;
    logic [1:0]  win;
    logic [15:0] mt;
    logic        tie;
    logic        to;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_pass = 0;

  int          m_done_cnt, m_done_edge, m_q_cnt, m_q_first;
  logic [1:0]  m_win;
  logic [15:0] m_mt;
  logic        m_tie, m_to;
  int          m4_done_cnt, m4_done_edge, m4_q_cnt;
  logic        m4_to;

  // Advance one clock edge; afterwards we sit 1 time unit past it.
  task automatic edge_n();
    @(posedge aclk); #1;
  endtask

  // Opens a gamma cycle: gamma_rst sampled at "edge 0".
  task automatic start_gamma(input logic md, input logic [3:0] en);
    gamma_rst = 1'b1; mode = md; in_en = en; spike = 4'h0;
    edge_n();
    gamma_rst = 1'b0; mode = ~md; in_en = ~en;  // later changes must not matter
  endtask

  // Drives sched[e] for edges 1..ncyc and records what both DUTs produce.
  task automatic run_sched(input sched_t s, input int ncyc);
    m_done_cnt = 0; m_done_edge = -1; m_q_cnt = 0; m_q_first = -1;
    m_win = '0; m_mt = '0; m_tie = 1'b0; m_to = 1'b0;
    m4_done_cnt = 0; m4_done_edge = -1; m4_q_cnt = 0; m4_to = 1'b0;
    for (int e = 1; e <= ncyc; e++) begin
      spike = s[e];
      edge_n();
      if (done) begin
        m_done_cnt++;
        if (m_done_edge < 0) begin
          m_done_edge = e; m_win = winner; m_mt = max_time; m_tie = tie; m_to = timeout;
        end
      end
      if (q) begin m_q_cnt++; if (m_q_first < 0) m_q_first = e; end
      if (done4) begin
        m4_done_cnt++;
        if (m4_done_edge < 0) begin m4_done_edge = e; m4_to = timeout4; end
      end
      if (q4) m4_q_cnt++;
    end
    spike = 4'h0;
  endtask

  task automatic test_reset();
    grst_n = 1'b0; gamma_rst = 1'b0; mode = 1'b0; in_en = 4'h0; spike = 4'h0;
    repeat (3) edge_n();
    n_chk++; if (q !== 1'b0)         $display("FAIL rst_q got %b want 0", q); else n_pass++;
    n_chk++; if (winner !== 2'd0)    $display("FAIL rst_winner got %0d want 0", winner); else n_pass++;
    n_chk++; if (max_time !== 16'd0) $display("FAIL rst_max_time got %0d want 0", max_time); else n_pass++;
    n_chk++; if (tie !== 1'b0)       $display("FAIL rst_tie got %b want 0", tie); else n_pass++;
    n_chk++; if (timeout !== 1'b0)   $display("FAIL rst_timeout got %b want 0", timeout); else n_pass++;
    n_chk++; if (done !== 1'b0)      $display("FAIL rst_done got %b want 0", done); else n_pass++;
    grst_n = 1'b1;
    edge_n();
  endtask

  task automatic test_staggered();
    sched_t s; exp_t x;
    for (int e = 0; e < 24; e++) s[e] = {e >= 9, e >= 3, e >= 5, e >= 2};
    start_gamma(1'b0, 4'hF);
    sbq.push_back('{9, 9, 8, 2'd3, 16'd8, 1'b0, 1'b0});
    run_sched(s, 22);
    x = sbq.pop_front();
    n_chk++; if (m_done_cnt !== 1)          $display("FAIL stag_done_cnt got %0d want 1", m_done_cnt); else n_pass++;
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL stag_done_edge got %0d want %0d", m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_q_first !== x.q_first)   $display("FAIL stag_q_first got %0d want %0d", m_q_first, x.q_first); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)       $display("FAIL stag_q_cnt got %0d want %0d", m_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_win !== x.win)           $display("FAIL stag_winner got %0d want %0d", m_win, x.win); else n_pass++;
    n_chk++; if (m_mt !== x.mt)             $display("FAIL stag_max_time got %0d want %0d", m_mt, x.mt); else n_pass++;
    n_chk++; if (m_tie !== x.tie)           $display("FAIL stag_tie got %b want %b", m_tie, x.tie); else n_pass++;
  endtask

  task automatic test_tie(input logic md);
    sched_t s; exp_t x;
    for (int e = 0; e < 24; e++) s[e] = {e >= 6, e >= 3, e >= 6, e >= 2};
    start_gamma(md, 4'hF);
    if (md) sbq.push_back('{6, -1, 0, 2'd1, 16'd5, 1'b1, 1'b0});
    else    sbq.push_back('{6,  6, 8, 2'd1, 16'd5, 1'b1, 1'b0});
    run_sched(s, 18);
    x = sbq.pop_front();
    n_chk++; if (m_done_cnt !== 1)            $display("FAIL tie%0d_done_cnt got %0d want 1", md, m_done_cnt); else n_pass++;
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL tie%0d_done_edge got %0d want %0d", md, m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_q_first !== x.q_first)     $display("FAIL tie%0d_q_first got %0d want %0d", md, m_q_first, x.q_first); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)         $display("FAIL tie%0d_q_cnt got %0d want %0d", md, m_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_win !== x.win)             $display("FAIL tie%0d_winner got %0d want %0d", md, m_win, x.win); else n_pass++;
    n_chk++; if (m_tie !== x.tie)             $display("FAIL tie%0d_tie got %b want %b", md, m_tie, x.tie); else n_pass++;
  endtask

  task automatic test_masked();
    sched_t s; exp_t x;
    for (int e = 0; e < 24; e++) s[e] = {1'b0, e >= 7, e >= 4, e >= 1};
    start_gamma(1'b0, 4'b0111);
    sbq.push_back('{7, 7, 8, 2'd2, 16'd6, 1'b0, 1'b0});
    run_sched(s, 18);
    x = sbq.pop_front();
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL mask_done_edge got %0d want %0d", m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)         $display("FAIL mask_q_cnt got %0d want %0d", m_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_win !== x.win)             $display("FAIL mask_winner got %0d want %0d", m_win, x.win); else n_pass++;
    n_chk++; if (m_mt !== x.mt)               $display("FAIL mask_max_time got %0d want %0d", m_mt, x.mt); else n_pass++;
  endtask

  task automatic test_timeout();
    sched_t s; exp_t x;
    for (int e = 0; e < 24; e++) s[e] = {1'b0, e >= 1, e >= 1, e >= 1};
    start_gamma(1'b0, 4'hF);
    // narrow DUT: t_cnt reaches 15 at edge 16
    sbq.push_back('{16, -1, 0, 2'd0, 16'd0, 1'b0, 1'b1});
    run_sched(s, 22);
    x = sbq.pop_front();
    n_chk++; if (m4_done_edge !== x.done_edge) $display("FAIL tmo_done_edge got %0d want %0d", m4_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m4_done_cnt !== 1)            $display("FAIL tmo_done_cnt got %0d want 1", m4_done_cnt); else n_pass++;
    n_chk++; if (m4_to !== x.to)               $display("FAIL tmo_timeout got %b want %b", m4_to, x.to); else n_pass++;
    n_chk++; if (m4_q_cnt !== x.q_cnt)         $display("FAIL tmo_q_cnt got %0d want %0d", m4_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_done_cnt !== 0)             $display("FAIL tmo_wide_done_cnt got %0d want 0", m_done_cnt); else n_pass++;
    n_chk++; if (timeout !== 1'b0)             $display("FAIL tmo_wide_timeout got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_gamma_mid_pulse();
    sched_t s; exp_t x;
    start_gamma(1'b0, 4'hF);
    spike = 4'b0111; edge_n(); edge_n();
    spike = 4'b1111; edge_n();            // completes at edge 3
    edge_n(); edge_n();                   // third FIRE cycle now
    n_chk++; if (q !== 1'b1)      $display("FAIL mid_q_before got %b want 1", q); else n_pass++;
    n_chk++; if (winner !== 2'd3) $display("FAIL mid_winner_before got %0d want 3", winner); else n_pass++;
    start_gamma(1'b0, 4'hF);
    n_chk++; if (q !== 1'b0)         $display("FAIL mid_q got %b want 0", q); else n_pass++;
    n_chk++; if (winner !== 2'd0)    $display("FAIL mid_winner got %0d want 0", winner); else n_pass++;
    n_chk++; if (max_time !== 16'd0) $display("FAIL mid_max_time got %0d want 0", max_time); else n_pass++;
    n_chk++; if (done !== 1'b0)      $display("FAIL mid_done got %b want 0", done); else n_pass++;
    for (int e = 0; e < 24; e++) s[e] = {e >= 4, e >= 1, e >= 1, e >= 2};
    sbq.push_back('{4, 4, 8, 2'd3, 16'd3, 1'b0, 1'b0});
    run_sched(s, 16);
    x = sbq.pop_front();
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL mid_new_done_edge got %0d want %0d", m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)         $display("FAIL mid_new_q_cnt got %0d want %0d", m_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_mt !== x.mt)               $display("FAIL mid_new_max_time got %0d want %0d", m_mt, x.mt); else n_pass++;
  endtask

  task automatic test_async_reset();
    sched_t s; exp_t x;
    start_gamma(1'b1, 4'b0011);
    spike = 4'b0001; edge_n();
    spike = 4'b0011; edge_n();            // completes at edge 2, no tie
    edge_n();
    n_chk++; if (q !== 1'b1)          $display("FAIL arst_q_before got %b want 1", q); else n_pass++;
    n_chk++; if (max_time !== 16'd1)  $display("FAIL arst_max_time_before got %0d want 1", max_time); else n_pass++;
    #2; grst_n = 1'b0; spike = 4'h0; #1;
    n_chk++; if (q !== 1'b0)         $display("FAIL arst_q got %b want 0", q); else n_pass++;
    n_chk++; if (winner !== 2'd0)    $display("FAIL arst_winner got %0d want 0", winner); else n_pass++;
    n_chk++; if (max_time !== 16'd0) $display("FAIL arst_max_time got %0d want 0", max_time); else n_pass++;
    #2; grst_n = 1'b1;
    // No gamma_rst: restored config is mode 0, all channels enabled.
    for (int e = 0; e < 24; e++) s[e] = {e >= 3, e >= 3, e >= 1, e >= 1};
    sbq.push_back('{3, 3, 8, 2'd2, 16'd2, 1'b1, 1'b0});
    run_sched(s, 14);
    x = sbq.pop_front();
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL arst_new_done_edge got %0d want %0d", m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)         $display("FAIL arst_new_q_cnt got %0d want %0d", m_q_cnt, x.q_cnt); else n_pass++;
    n_chk++; if (m_win !== x.win)             $display("FAIL arst_new_winner got %0d want %0d", m_win, x.win); else n_pass++;
    n_chk++; if (m_mt !== x.mt)               $display("FAIL arst_new_max_time got %0d want %0d", m_mt, x.mt); else n_pass++;
    n_chk++; if (m_tie !== x.tie)             $display("FAIL arst_new_tie got %b want %b", m_tie, x.tie); else n_pass++;
  endtask

  task automatic test_duplicate();
    sched_t s; exp_t x;
    // spike[0] pulses at edge 2, drops, rises again with spike[3] at edge 6
    for (int e = 0; e < 24; e++) s[e] = {e >= 6, e >= 4, e >= 4, (e == 2) || (e >= 6)};
    start_gamma(1'b0, 4'hF);
    sbq.push_back('{6, 6, 8, 2'd3, 16'd5, 1'b0, 1'b0});
    run_sched(s, 16);
    x = sbq.pop_front();
    n_chk++; if (m_done_edge !== x.done_edge) $display("FAIL dup_done_edge got %0d want %0d", m_done_edge, x.done_edge); else n_pass++;
    n_chk++; if (m_win !== x.win)             $display("FAIL dup_winner got %0d want %0d", m_win, x.win); else n_pass++;
    n_chk++; if (m_mt !== x.mt)               $display("FAIL dup_max_time got %0d want %0d", m_mt, x.mt); else n_pass++;
    n_chk++; if (m_tie !== x.tie)             $display("FAIL dup_tie got %b want %b", m_tie, x.tie); else n_pass++;
    n_chk++; if (m_q_cnt !== x.q_cnt)         $display("FAIL dup_q_cnt got %0d want %0d", m_q_cnt, x.q_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_tie(1'b1);
    test_tie(1'b0);
    test_masked();
    test_timeout();
    test_gamma_mid_pulse();
    test_async_reset();
    test_duplicate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
